// File: rtl/sdes_if.sv
// sdes_if: host-side key load and block valid/ready bundle
// for the iterative S-DES round sequencer.
interface sdes_if #(
  parameter int CNT_W = 16
);
  logic             key_load;
  logic [9:0]       key_in;
  logic             key_ok;
  logic             in_valid;
  logic             in_ready;
  logic             in_decrypt;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;

  modport master (
    output key_load, key_in,
    output in_valid, in_decrypt, in_data,
    output out_ready,
    input  key_ok, in_ready,
    input  out_valid, out_data,
    input  busy, blk_cnt
  );

  modport slave (
    input  key_load, key_in,
    input  in_valid, in_decrypt, in_data,
    input  out_ready,
    output key_ok, in_ready,
    output out_valid, out_data,
    output busy, blk_cnt
  );
endinterface

// File: rtl/sdes_round_sequencer.sv
// sdes_round_sequencer: iterative S-DES engine; one Fk datapath
// shared by both rounds, plus key schedule and block handshake.
module sdes_round_sequencer #(
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   rst_n,
  sdes_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KG1  = 3'd1;
  localparam logic [2:0] S_KG2  = 3'd2;
  localparam logic [2:0] S_RND1 = 3'd3;
  localparam logic [2:0] S_RND2 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] S0 [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1 [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  logic [2:0]       r_state;
  logic [9:0]       r_key;
  logic [7:0]       r_k1;
  logic [7:0]       r_k2;
  logic [3:0]       r_l;
  logic [3:0]       r_r;
  logic             r_dec;
  logic             r_key_ok;
  logic             r_out_valid;
  logic [7:0]       r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [9:0] w_p10;
  logic [9:0] w_ls1;
  logic [9:0] w_ls2;
  logic [7:0] w_ip;
  logic [7:0] w_ep;
  logic [7:0] w_rkey;
  logic [7:0] w_x;
  logic [1:0] w_s0;
  logic [1:0] w_s1;
  logic [3:0] w_sb;
  logic [3:0] w_f;
  logic [7:0] w_fin;
  logic [7:0] w_ipi;
  logic       w_acc;

  function automatic logic [7:0] f_p8(
    input logic [9:0] k
  );
    return {k[4], k[7], k[3], k[6],
            k[2], k[5], k[0], k[1]};
  endfunction

  assign w_p10 = {bus.key_in[7], bus.key_in[5],
                  bus.key_in[8], bus.key_in[3],
                  bus.key_in[6], bus.key_in[0],
                  bus.key_in[9], bus.key_in[1],
                  bus.key_in[2], bus.key_in[4]};

  assign w_ls1 = {r_key[8:5], r_key[9],
                  r_key[3:0], r_key[4]};
  assign w_ls2 = {r_key[7:5], r_key[9:8],
                  r_key[2:0], r_key[4:3]};

  assign w_ip = {bus.in_data[6], bus.in_data[2],
                 bus.in_data[5], bus.in_data[7],
                 bus.in_data[4], bus.in_data[0],
                 bus.in_data[3], bus.in_data[1]};

  // RND1 uses K1 for encrypt, RND2 uses K1 for decrypt
  assign w_rkey = ((r_state == S_RND1) ^ r_dec)
                ? r_k1 : r_k2;

  assign w_ep = {r_r[0], r_r[3], r_r[2], r_r[1],
                 r_r[2], r_r[1], r_r[0], r_r[3]};
  assign w_x  = w_ep ^ w_rkey;
  assign w_s0 = S0[{w_x[7], w_x[4], w_x[6], w_x[5]}];
  assign w_s1 = S1[{w_x[3], w_x[0], w_x[2], w_x[1]}];
  assign w_sb = {w_s0, w_s1};
  assign w_f  = {w_sb[2], w_sb[0], w_sb[1], w_sb[3]};

  assign w_fin = {r_l ^ w_f, r_r};
  assign w_ipi = {w_fin[4], w_fin[7], w_fin[5], w_fin[3],
                  w_fin[1], w_fin[6], w_fin[0], w_fin[2]};

  assign bus.in_ready  = (r_state == S_IDLE) && r_key_ok
                      && !bus.key_load;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign bus.key_ok    = r_key_ok;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.blk_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key       <= '0;
      r_k1        <= '0;
      r_k2        <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_dec       <= 1'b0;
      r_key_ok    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.key_load) begin
            r_key    <= w_p10;
            r_key_ok <= 1'b0;
            r_state  <= S_KG1;
          end else if (w_acc) begin
            r_l     <= w_ip[7:4];
            r_r     <= w_ip[3:0];
            r_dec   <= bus.in_decrypt;
            r_state <= S_RND1;
          end
        end
        S_KG1: begin
          r_key   <= w_ls1;
          r_k1    <= f_p8(w_ls1);
          r_state <= S_KG2;
        end
        S_KG2: begin
          r_key    <= w_ls2;
          r_k2     <= f_p8(w_ls2);
          r_key_ok <= 1'b1;
          r_state  <= S_IDLE;
        end
        S_RND1: begin
          r_l     <= r_r;
          r_r     <= r_l ^ w_f;
          r_state <= S_RND2;
        end
        S_RND2: begin
          r_out       <= w_ipi;
          r_out_valid <= 1'b1;
          if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdes_round_sequencer.sv
// tb_sdes_round_sequencer: randomized bench against a table-driven
// S-DES model; a CNT_W=2 twin shares stimulus to cover saturation.
module tb_sdes_round_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdes_if #(.CNT_W(16)) bus();
  sdes_if #(.CNT_W(2))  bus2();

  sdes_round_sequencer #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sdes_round_sequencer #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.key_load   = bus.key_load;
  assign bus2.key_in     = bus.key_in;
  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_decrypt = bus.in_decrypt;
  assign bus2.in_data    = bus.in_data;
  assign bus2.out_ready  = bus.out_ready;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int blk_model = 0;
  logic [7:0] mk1, mk2;

  int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  int S0M[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0},
                    '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1M[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3},
                    '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  // Standard bit n (1-based) of an m-bit value sits at v[m-n]
  function automatic logic [9:0] perm(
    input logic [9:0] v, input int n_in,
    input int n_out, input int t[10]
  );
    logic [9:0] r;
    r = '0;
    for (int j = 1; j <= n_out; j++)
      r[n_out - j] = v[n_in - t[j-1]];
    return r;
  endfunction

  function automatic logic [4:0] rol5(
    input logic [4:0] v, input int n
  );
    logic [4:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[3:0], r[4]};
    return r;
  endfunction

  function automatic logic [3:0] fmod(
    input logic [3:0] r, input logic [7:0] k
  );
    logic [9:0] e;
    logic [9:0] p;
    logic [7:0] x;
    int s0, s1, r0, c0, r1, c1;
    e  = perm({6'b0, r}, 4, 8, EP_T);
    x  = e[7:0] ^ k;
    r0 = 2 * int'(x[7]) + int'(x[4]);
    c0 = 2 * int'(x[6]) + int'(x[5]);
    r1 = 2 * int'(x[3]) + int'(x[0]);
    c1 = 2 * int'(x[2]) + int'(x[1]);
    s0 = S0M[r0][c0];
    s1 = S1M[r1][c1];
    p  = perm({6'b0, s0[1:0], s1[1:0]}, 4, 4, P4_T);
    return p[3:0];
  endfunction

  function automatic logic [7:0] sdes(
    input logic [7:0] d, input logic [7:0] ka,
    input logic [7:0] kb
  );
    logic [9:0] ip, o;
    logic [3:0] l1, r1, l2;
    ip = perm({2'b0, d}, 8, 8, IP_T);
    r1 = ip[7:4] ^ fmod(ip[3:0], ka);
    l2 = r1;
    r1 = ip[3:0];
    l1 = r1 ^ fmod(l2, kb);
    o  = perm({2'b0, l1, l2}, 8, 8, IPI_T);
    return o[7:0];
  endfunction

  function automatic logic [7:0] model(
    input logic [7:0] d, input logic dec
  );
    return dec ? sdes(d, mk2, mk1) : sdes(d, mk1, mk2);
  endfunction

  task automatic set_model_key(input logic [9:0] k);
    logic [9:0] p, q;
    p   = perm(k, 10, 10, P10_T);
    q   = perm({rol5(p[9:5], 1), rol5(p[4:0], 1)},
               10, 8, P8_T);
    mk1 = q[7:0];
    q   = perm({rol5(p[9:5], 3), rol5(p[4:0], 3)},
               10, 8, P8_T);
    mk2 = q[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [9:0] k);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    tick();
    bus.key_load = 1'b0;
    tick();
    tick();
    set_model_key(k);
  endtask

  task automatic run_block(
    input logic [7:0] d, input logic dec,
    input logic keep_rdy,
    output logic [7:0] res, output int lat
  );
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_wait got=%b want=1",
               bus.in_ready);
    end
    bus.in_data    = d;
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    blk_model++;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    res = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = keep_rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({bus.key_ok, bus.out_valid, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000",
               {bus.key_ok, bus.out_valid, bus.busy});
    end
    n_cmp++;
    if (bus.out_data !== 8'h00 || bus.blk_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h want=00/0000",
               bus.out_data, bus.blk_cnt);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nokey_ready got=%b want=0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nokey_accept busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_keygen();
    bus.key_load = 1'b1;
    bus.key_in   = 10'b1010000010;
    tick();
    bus.key_load = 1'b0;
    n_cmp++;
    if (bus.key_ok !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL keygen_mid ok/busy got=%b%b want=01",
               bus.key_ok, bus.busy);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.key_ok !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL keygen_done ok/busy got=%b%b want=10",
               bus.key_ok, bus.busy);
    end
    set_model_key(10'b1010000010);
  endtask

  task automatic test_known_answer();
    logic [7:0] res;
    int lat;
    run_block(8'b10010111, 1'b0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 8'b00111000 || res !== model(8'b10010111, 1'b0)) begin
      n_fail++;
      $display("FAIL kat_enc got=%b want=00111000", res);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL kat_latency got=%0d want=3", lat);
    end
    n_cmp++;
    if (bus.blk_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL kat_cnt got=%0d want=1", bus.blk_cnt);
    end
    run_block(8'b00111000, 1'b1, 1'b0, res, lat);
    n_cmp++;
    if (res !== 8'b10010111) begin
      n_fail++;
      $display("FAIL kat_dec got=%b want=10010111", res);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d, held, want;
    logic dec;
    int w;
    d    = 8'($urandom);
    dec  = 1'($urandom);
    want = model(d, dec);
    bus.in_data    = d;
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_data    = ~d;
    bus.in_decrypt = ~dec;
    blk_model++;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    held = bus.out_data;
    n_cmp++;
    if (held !== want) begin
      n_fail++;
      $display("FAIL stall_data got=%h want=%h", held, want);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d v/d/rdy got=%b/%h/%b want=1/%h/0",
                 i, bus.out_valid, bus.out_data, bus.in_ready, held);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release v/rdy got=%b%b want=01",
               bus.out_valid, bus.in_ready);
    end
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    blk_model++;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_next_accept busy got=%b want=1", bus.busy);
    end
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, res;
    logic dec;
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      dec = 1'($urandom);
      run_block(d, dec, 1'b1, res, lat);
      n_cmp++;
      if (res !== model(d, dec) || lat !== 3 ||
          bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b%0d res/lat/rdy got=%h/%0d/%b want=%h/3/1",
                 i, res, lat, bus.in_ready, model(d, dec));
      end
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.blk_cnt !== 16'(blk_model)) begin
      n_fail++;
      $display("FAIL b2b_cnt got=%0d want=%0d", bus.blk_cnt, blk_model);
    end
  endtask

  task automatic test_random_keys();
    logic [9:0] k;
    logic [7:0] d, res;
    logic dec;
    int lat;
    for (int i = 0; i < 8; i++) begin
      k = 10'($urandom);
      load_key(k);
      d   = 8'($urandom);
      dec = 1'($urandom);
      run_block(d, dec, 1'b0, res, lat);
      n_cmp++;
      if (res !== model(d, dec)) begin
        n_fail++;
        $display("FAIL rand%0d key=%b d=%h dec=%b got=%h want=%h",
                 i, k, d, dec, res, model(d, dec));
      end
    end
  endtask

  task automatic test_key_priority();
    logic [9:0] ka, kb;
    logic [7:0] d, res, want;
    int lat, w;
    ka = 10'($urandom);
    kb = ~ka;
    bus.key_load = 1'b1;
    bus.key_in   = ka;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_ready got=%b want=0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.key_in   = kb;
    tick();
    bus.key_load = 1'b0;
    n_cmp++;
    if (bus.key_ok !== 1'b0 || bus.busy !== 1'b1 ||
        bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_kg ok/busy/v got=%b%b%b want=010",
               bus.key_ok, bus.busy, bus.out_valid);
    end
    tick();
    set_model_key(ka);
    d = 8'($urandom);
    run_block(d, 1'b0, 1'b0, res, lat);
    n_cmp++;
    if (res !== model(d, 1'b0)) begin
      n_fail++;
      $display("FAIL collide_key got=%h want=%h", res, model(d, 1'b0));
    end
    d = 8'($urandom);
    want = model(d, 1'b1);
    bus.in_data    = d;
    bus.in_decrypt = 1'b1;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.key_load = 1'b1;
    bus.key_in   = kb;
    tick();
    bus.key_load = 1'b0;
    blk_model++;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_cmp++;
    if (bus.out_data !== want || bus.key_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_keyload got=%h ok=%b want=%h ok=1",
               bus.out_data, bus.key_ok, want);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic seen;
    bus.in_data    = 8'($urandom);
    bus.in_decrypt = 1'b0;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    blk_model = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || bus.key_ok !== 1'b0 ||
        bus.blk_cnt !== 16'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort v/ok/cnt/busy got=%b/%b/%0d/%b want=0/0/0/0",
               seen, bus.key_ok, bus.blk_cnt, bus.busy);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] d, res;
    int lat, sat;
    load_key(10'($urandom));
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      run_block(d, 1'b0, 1'b0, res, lat);
      sat = (blk_model > 3) ? 3 : blk_model;
      n_cmp++;
      if (bus.blk_cnt !== 16'(blk_model) ||
          bus2.blk_cnt !== 2'(sat) ||
          bus2.out_data !== res) begin
        n_fail++;
        $display("FAIL sat%0d cnt16/cnt2 got=%0d/%0d want=%0d/%0d",
                 i, bus.blk_cnt, bus2.blk_cnt, blk_model, sat);
      end
    end
  endtask

  initial begin
    bus.key_load   = 1'b0;
    bus.key_in     = '0;
    bus.in_valid   = 1'b0;
    bus.in_decrypt = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_keygen();
    test_known_answer();
    test_stall();
    test_back_to_back();
    test_random_keys();
    test_key_priority();
    test_abort();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdes_round_sequencer.md
Name: sdes_round_sequencer

Overview:
- Iterative S-DES engine controller: one shared Fk datapath (E/P, subkey XOR, one S0 and one S1 instance, P4) is time-shared across both rounds of encryption or decryption.
- Handles key loading and subkey generation (P10, LS-1, LS-2, P8).
- Sequences IP, round 1, swap, round 2 and IP^-1.
- Sits between the host-side valid/ready block interface and the existing S-box/permutation leaf modules.

Parameters:
- CNT_W, 16: width of the saturating completed-block counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  pulse: capture key_in and start subkey generation
- key_in  in  10  S-DES key; bit 9 is standard key bit 1
- key_ok  out  1  subkeys valid
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- in_decrypt  in  1  sampled with block: 1 = decrypt (K2 then K1)
- in_data  in  8  block; bit 7 is standard bit 1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  8  result block
- busy  out  1  state != IDLE
- blk_cnt  out  CNT_W  completed blocks, saturating

Behaviour:

Interface:
- Clock is clk; reset is rst_n, synchronous and active-low. Reset is sampled only on the rising edge of clk.

Reset:
- state = IDLE.
- key_ok, out_valid, busy = 0.
- out_data, blk_cnt = 0.
- K1, K2, L, R, key register = 0.
- Reset asserted in any state aborts the operation: no output, key invalidated.

States:
- IDLE, KEYGEN1, KEYGEN2, RND1, RND2, DONE.

IDLE:
- key_load = 1: capture P10(key_in), clear key_ok, go to KEYGEN1.
- key_load = 0 and in_valid && in_ready: capture IP(in_data) into {L,R}, capture in_decrypt, go to RND1.
- in_ready = (state == IDLE) && key_ok && !key_load. key_load has priority over a same-cycle block.

KEYGEN1:
- Apply LS-1 to both 5-bit halves, K1 <= P8(result), go to KEYGEN2.

KEYGEN2:
- Apply a further LS-2 to both halves, K2 <= P8(result), key_ok <= 1, go to IDLE.
- Subkey generation is two cycles after the key_load edge.

RND1:
- Round key is K1 (encrypt) or K2 (decrypt).
- L <= R; R <= L ^ F(R, key). The swap is folded into this update.
- Go to RND2.

RND2:
- Round key is K2 (encrypt) or K1 (decrypt).
- out_data <= IP^-1({L ^ F(R, key), R}); out_valid <= 1.
- blk_cnt increments, saturating at 2^CNT_W - 1.
- Go to DONE.

DONE:
- out_valid = 1; out_data held stable.
- out_valid && out_ready: out_valid <= 0, go to IDLE. A new block can be accepted on the following cycle.
- Latency: accept edge to out_valid high is 3 edges (RND1, RND2, DONE entry). Throughput is at most one block per 4 cycles.

F(R, k):
- P4 of {S0(row/col of (EP(R)^k)[7:4]), S1(...[3:0])}.
- S-box input: bits 3 and 0 form the row, bits 2 and 1 form the column.
- The shared S0/S1 instances are used exactly once per round cycle.

Boundaries:
- key_load outside IDLE: ignored.
- in_valid while key_ok = 0: not accepted; in_ready = 0.
- in_data and in_decrypt changing after acceptance: no effect.
- out_ready high before out_valid: no effect.
- Held out_ready: the block completes and the engine returns to IDLE with no extra bubble beyond DONE.
- Back-to-back key_load pulses: each must occur in IDLE; the second restarts KEYGEN.

Test Plan:
- Reset, key_load with key 1010000010, wait 2 cycles → key_ok = 1, K1 = 10100100, K2 = 01000011.
- Encrypt in_data 10010111 → out_valid 3 edges after accept, out_data = 00111000, blk_cnt = 1.
- Decrypt in_data 00111000, in_decrypt = 1, same key → out_data = 10010111.
- Hold out_ready = 0 for 5 cycles in DONE → out_valid and out_data stable, in_ready = 0. Raise out_ready → IDLE, next block accepted one cycle later.
- key_load and in_valid asserted together in IDLE → block not accepted, KEYGEN entered. rst_n low during RND1 → out_valid never asserts, key_ok = 0.
- CNT_W = 2, run 5 blocks → blk_cnt saturates at 3.
